// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract unit with one full-adder slice and one carry flop, LSB-first.
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset
//   start  - request an operation (sampled only in IDLE)
//   sub    - 0 = a+b, 1 = a-b (sampled with start)
//   a, b   - WIDTH-bit operands (sampled with start)
//   busy   - high while not IDLE
//   done   - one-cycle pulse when result/cout/ovf are valid
//   result - WIDTH-bit sum/difference, held until the next accepted start
//   cout   - final carry out (sub: 1 = no borrow)
//   ovf    - signed two's-complement overflow
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic s, c_n, last;
    assign s = ra_q[0] ^ rb_q[0] ^ carry_q;
    assign c_n = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
    assign last = cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = last ? FIN : SHIFT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy = state_q != IDLE;
        done = state_q == FIN;
    end
    // Subtraction runs through the same adder as a + ~b with carry-in 1.
    // Overflow is carry into the MSB xor carry out of it, both visible on the last slice.
    always_comb begin
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && start) begin
            ra_d     = a;
            rb_d     = sub ? ~b : b;
            carry_d  = sub;
            cnt_d    = '0;
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == SHIFT) begin
            carry_d  = c_n;
            result_d = {s, result_q[WIDTH-1:1]};
            ra_d     = ra_q >> 1;
            rb_d     = rb_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            cout_d   = last ? c_n : cout_q;
            ovf_d    = last ? carry_q ^ c_n : ovf_q;
        end
    end
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed self-checking bench for serial_addsub (WIDTH=8).
module tb_serial_addsub;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, cout, ovf;
    logic [7:0] result;
    int checks = 0, failures = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                         output int bc, output int dc, output int dat);
        bc = 0;
        dc = 0;
        dat = -1;
        @(negedge clk);
        a = oa;
        b = ob;
        sub = osub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~oa;
        b = ~ob;
        sub = ~osub;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            bc++;
            if (done) begin
                dc++;
                dat = i;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, cout, ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0", busy, done, result, cout, ovf);
        end
        reset = 1'b1;
    endtask

    task automatic test_add();
        int bc, dc, dat;
        do_op(8'h0F, 8'h01, 1'b0, bc, dc, dat);
        checks++;
        if (bc !== 9) begin failures++; $display("FAIL add_busy_cycles: got %0d required 9", bc); end
        checks++;
        if (dc !== 1 || dat !== 8) begin failures++; $display("FAIL add_done_timing: pulses=%0d at=%0d required 1 at 8", dc, dat); end
        checks++;
        if ({result, cout, ovf} !== {8'h10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_0F_01: result=%h cout=%b ovf=%b required 10 0 0", result, cout, ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, result, cout, ovf} !== {1'b0, 8'h10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_hold: busy=%b result=%h cout=%b ovf=%b required 0 10 0 0", busy, result, cout, ovf);
        end
        do_op(8'hFF, 8'h01, 1'b0, bc, dc, dat);
        checks++;
        if ({result, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_FF_01: result=%h cout=%b ovf=%b required 00 1 0", result, cout, ovf);
        end
        do_op(8'h7F, 8'h01, 1'b0, bc, dc, dat);
        checks++;
        if ({result, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_7F_01: result=%h cout=%b ovf=%b required 80 0 1", result, cout, ovf);
        end
    endtask

    task automatic test_sub();
        int bc, dc, dat;
        do_op(8'h05, 8'h07, 1'b1, bc, dc, dat);
        checks++;
        if ({result, cout, ovf} !== {8'hFE, 1'b0, 1'b0} || dc !== 1) begin
            failures++;
            $display("FAIL sub_05_07: result=%h cout=%b ovf=%b done=%0d required FE 0 0 1", result, cout, ovf, dc);
        end
        do_op(8'h80, 8'h01, 1'b1, bc, dc, dat);
        checks++;
        if ({result, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_80_01: result=%h cout=%b ovf=%b required 7F 1 1", result, cout, ovf);
        end
        do_op(8'h5A, 8'h5A, 1'b1, bc, dc, dat);
        checks++;
        if ({result, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_x_x: result=%h cout=%b ovf=%b required 00 1 0", result, cout, ovf);
        end
    endtask

    task automatic test_ignore_start();
        int dc = 0;
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 2 && i <= 4) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end else start = 1'b0;
            if (done) dc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dc !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d required 1", dc); end
        checks++;
        if ({busy, result} !== {1'b0, 8'h30}) begin
            failures++;
            $display("FAIL ignore_result: busy=%b result=%h required 0 30", busy, result);
        end
    endtask

    task automatic test_abort();
        int bc, dc = 0, dat;
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result} !== 10'h000) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b result=%h required 0 0 00", busy, done, result);
        end
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (done) dc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dc !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses required 0", dc); end
        do_op(8'h01, 8'h01, 1'b0, bc, dc, dat);
        checks++;
        if ({result, dc} !== {8'h02, 32'd1}) begin
            failures++;
            $display("FAIL abort_fresh_op: result=%h done=%0d required 02 1", result, dc);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc, dat, errs = 0;
        logic [7:0] va, vb, er;
        logic [8:0] wide;
        logic ec, eo;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) begin
                for (int j = 0; j < 32; j++) begin
                    va = 8'((i * 37 + j) % 256);
                    vb = 8'((j * 29 + 3 + i) % 256);
                    if (i == 0) va = 8'hFF;
                    if (j == 0) vb = 8'h80;
                    wide = (s == 1) ? 9'(va) + 9'(8'(~vb)) + 9'd1 : 9'(va) + 9'(vb);
                    er = wide[7:0];
                    ec = wide[8];
                    eo = (s == 1) ? (va[7] != vb[7]) && (er[7] != va[7])
                                  : (va[7] == vb[7]) && (er[7] != va[7]);
                    do_op(va, vb, s[0], bc, dc, dat);
                    checks++;
                    if ({result, cout, ovf, dc} !== {er, ec, eo, 32'd1}) begin
                        failures++;
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep sub=%0d %h,%h: result=%h cout=%b ovf=%b done=%0d required %h %b %b 1",
                                     s, va, vb, result, cout, ovf, dc, er, ec, eo);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
